// File: rtl/seq_pkg.sv
// Shared definitions for the serial path into the sequence detector.
//   ser_state_t : serializer FSM state (IDLE / SHIFT)
//   cnt_width() : bit-counter width for a given word width (ceil log2, min 1)
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Smallest r with (1 << r) >= w, never below 1 so a counter always exists.
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle for seq_serializer.
//   din/din_valid/din_ready : parallel word handshake (upstream -> serializer)
//   x_out/x_valid           : serial bit stream toward the detector
//   busy/word_done          : status (occupied, last bit of a word)
// slave  : the serializer side
// master : the upstream/observer side
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output din, din_valid,
        input  din_ready, x_out, x_valid, busy, word_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x_out, x_valid, busy, word_done
    );
endinterface

// File: rtl/ser_hold_reg.sv
// One-entry holding register with full flag.
//   clk, rst : clock, async active-low reset
//   din      : word to capture
//   load     : capture din and set full
//   unload   : word consumed; clears full unless load refills it
//   full     : entry occupied
//   dout     : held word
//   ready    : space available (= !full), from registered state only
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             unload,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             ready
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            dout <= '0;
        end else begin
            if (load) dout <= din;
            full <= load | (full & ~unload);
        end
    end

    assign ready = ~full;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// x_out. A one-word holding register lets consecutive words stream with no
// idle bit in between.
//   clk, rst : clock, async active-low reset
//   bus      : seq_serializer_if.slave (din handshake, x_out/x_valid,
//              busy, word_done)
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    seq_serializer_if.slave  bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic             hold_full;
    logic             hold_ready;
    logic [WIDTH-1:0] hold_q;
    logic             xfer;
    logic             last;
    logic             push;
    logic             pop;

    assign xfer = bus.din_valid & hold_ready;
    assign last = (state == SHIFT) && (cnt == '0);

    // A word accepted mid-word parks in the hold register; in the last-bit
    // cycle with hold empty it bypasses straight into the shifter instead.
    // In the last-bit cycle with hold full, ready is low so no push occurs.
    assign push = xfer && (state == SHIFT) && !last;
    assign pop  = last && hold_full;

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .din    (bus.din),
        .load   (push),
        .unload (pop),
        .full   (hold_full),
        .dout   (hold_q),
        .ready  (hold_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = SHIFT;
                    shreg_n = bus.din;
                    cnt_n   = CNT_LAST;
                end
            end
            SHIFT: begin
                if (!last) begin
                    shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg[WIDTH-1:1]};
                    cnt_n   = cnt - CW'(1);
                end else if (hold_full) begin
                    shreg_n = hold_q;
                    cnt_n   = CNT_LAST;
                end else if (xfer) begin
                    shreg_n = bus.din;
                    cnt_n   = CNT_LAST;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The outgoing bit is always the end of the shifter, so x_out is a
    // register bit gated only by the state register.
    assign bus.x_out     = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                            : IDLE_BIT;
    assign bus.x_valid   = (state == SHIFT);
    assign bus.word_done = last;
    assign bus.busy      = (state == SHIFT) | hold_full;
    assign bus.din_ready = hold_ready;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance share the
// same stimulus. The reference model is a queue of pending output bits per
// instance; the hold register is free whenever at most one word's worth of
// bits is still pending.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(W)) mif ();
    seq_serializer_if #(.WIDTH(W)) lif ();

    assign mif.din       = din;
    assign mif.din_valid = din_valid;
    assign lif.din       = din;
    assign lif.din_valid = din_valid;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (lif)
    );

    // Each entry is {last_bit_of_word, bit_value}.
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    int         vectors = 0;
    int         errs = 0;
    logic       acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic em_v, el_v;
        em_v = (qm.size() != 0);
        el_v = (ql.size() != 0);
        chk("msb_ready", 32'(mif.din_ready), 32'(qm.size() <= W));
        chk("msb_busy",  32'(mif.busy),      32'(em_v));
        chk("msb_xval",  32'(mif.x_valid),   32'(em_v));
        chk("msb_xout",  32'(mif.x_out),     em_v ? 32'(qm[0][0]) : 32'd0);
        chk("msb_done",  32'(mif.word_done), em_v ? 32'(qm[0][1]) : 32'd0);
        chk("lsb_ready", 32'(lif.din_ready), 32'(ql.size() <= W));
        chk("lsb_busy",  32'(lif.busy),      32'(el_v));
        chk("lsb_xval",  32'(lif.x_valid),   32'(el_v));
        chk("lsb_xout",  32'(lif.x_out),     el_v ? 32'(ql[0][0]) : 32'd0);
        chk("lsb_done",  32'(lif.word_done), el_v ? 32'(ql[0][1]) : 32'd0);
    endtask

    // One clock: advance the model at the rising edge, check at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            qm.delete();
            ql.delete();
            acc = 1'b0;
        end else begin
            acc = din_valid && (qm.size() <= W);
            if (qm.size() != 0) qm.delete(0);
            if (ql.size() != 0) ql.delete(0);
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back({i == W - 1, din[W-1-i]});
                    ql.push_back({i == W - 1, din[i]});
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Present a word and hold it until accepted; din_valid stays high after.
    task automatic offer(input logic [W-1:0] w);
        int n;
        din       = w;
        din_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        // Reset state
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single word 0x92, then idle
        offer(8'h92);
        din_valid = 1'b0;
        repeat (10) tick();

        // Three words back-to-back with backpressure
        offer(8'hA5);
        offer(8'h3C);
        offer(8'h5A);
        din_valid = 1'b0;
        repeat (26) tick();

        // 0x01: LSB-first instance emits 1 then seven 0s
        offer(8'h01);
        din_valid = 1'b0;
        repeat (10) tick();

        // Reset mid-word with a word held
        offer(8'hFF);
        offer(8'h77);
        din_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        check_all();
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();

        // Bypass: new word offered exactly in the last-bit cycle, hold empty
        offer(8'hC3);
        din_valid = 1'b0;
        repeat (7) tick();
        chk("bypass_lastbit", 32'(qm.size()), 32'd1);
        din       = 8'h4E;
        din_valid = 1'b1;
        tick();
        chk("bypass_acc", 32'(acc), 32'd1);
        din_valid = 1'b0;
        repeat (10) tick();

        // Randomized traffic; upstream holds a word until it is taken
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!din_valid || acc) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din       = W'($urandom);
            end
            tick();
        end
        din_valid = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
